// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg: state encoding and default sizes shared by the ALU share arbiter files.
package alu_share_arbiter_pkg;
    typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_FUNCW = 3;
endpackage

// File: rtl/alu_share_arbiter_rr_picker.sv
// alu_share_arbiter_rr_picker: combinational round-robin pick, first set bit at or above ptr, wrapping.
module alu_share_arbiter_rr_picker #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_win,
    output logic [PW-1:0]   o_idx,
    output logic            o_any
);
    logic          w_found;
    logic [PW-1:0] w_j;
    always_comb begin
        w_found = 1'b0;
        w_j     = '0;
        o_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = PW'((int'(i_ptr) + k) % NREQ);
            if (!w_found && i_req[w_j]) begin
                w_found = 1'b1;
                o_idx   = w_j;
            end
        end
    end
    assign o_any = |i_req;
    assign o_win = o_any ? (NREQ'(1) << o_idx) : '0;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU among NREQ requesters with round-robin grant,
// registered operands in and registered result out with a one-hot valid pulse to the owner.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int FUNCW = DEF_FUNCW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*WIDTH-1:0] i_req_a,
    input  logic [NREQ*WIDTH-1:0] i_req_b,
    input  logic [NREQ-1:0]       i_req_cin,
    input  logic [NREQ*FUNCW-1:0] i_req_func,
    output logic [NREQ-1:0]       o_gnt,
    output logic [NREQ-1:0]       o_rsp_valid,
    output logic [WIDTH-1:0]      o_rsp_w,
    output logic                  o_rsp_zero,
    output logic                  o_rsp_neg,
    output logic                  o_busy,
    output logic [WIDTH-1:0]      o_alu_a,
    output logic [WIDTH-1:0]      o_alu_b,
    output logic                  o_alu_cin,
    output logic [FUNCW-1:0]      o_alu_func,
    input  logic [WIDTH-1:0]      i_alu_w,
    input  logic                  i_alu_zero,
    input  logic                  i_alu_neg
);
    localparam int PW = $clog2(NREQ);
    state_t          r_state, w_state_nx;
    logic [PW-1:0]   r_owner, r_ptr, w_owner_inc, w_scan_ptr, w_win_idx;
    logic [NREQ-1:0] w_elig, w_win_oh;
    logic            w_any, w_issue, w_capture;
    logic [WIDTH-1:0] w_a [NREQ];
    logic [WIDTH-1:0] w_b [NREQ];
    logic [FUNCW-1:0] w_f [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_a[g] = i_req_a[g*WIDTH +: WIDTH];
        assign w_b[g] = i_req_b[g*WIDTH +: WIDTH];
        assign w_f[g] = i_req_func[g*FUNCW +: FUNCW];
    end
    assign w_owner_inc = (r_owner == PW'(NREQ-1)) ? '0 : r_owner + 1'b1;
    // While an op is in flight the scan already starts past the owner, whose req is masked
    assign w_scan_ptr  = (r_state == S_EXEC) ? w_owner_inc : r_ptr;
    assign w_elig      = i_req & ((r_state == S_EXEC) ? ~(NREQ'(1) << r_owner) : '1);
    alu_share_arbiter_rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
        .i_req (w_elig),
        .i_ptr (w_scan_ptr),
        .o_win (w_win_oh),
        .o_idx (w_win_idx),
        .o_any (w_any)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end
    always_comb begin
        w_state_nx = w_any ? S_EXEC : S_IDLE;
    end
    always_comb begin
        w_issue   = w_any;
        w_capture = (r_state == S_EXEC);
        o_busy    = (r_state != S_IDLE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_gnt       <= '0;
            o_rsp_valid <= '0;
            o_rsp_w     <= '0;
            o_rsp_zero  <= 1'b0;
            o_rsp_neg   <= 1'b0;
            o_alu_a     <= '0;
            o_alu_b     <= '0;
            o_alu_cin   <= 1'b0;
            o_alu_func  <= '0;
            r_owner     <= '0;
            r_ptr       <= '0;
        end else begin
            o_gnt       <= w_issue ? w_win_oh : '0;
            o_rsp_valid <= w_capture ? (NREQ'(1) << r_owner) : '0;
            if (w_issue) begin
                o_alu_a    <= w_a[w_win_idx];
                o_alu_b    <= w_b[w_win_idx];
                o_alu_cin  <= i_req_cin[w_win_idx];
                o_alu_func <= w_f[w_win_idx];
                r_owner    <= w_win_idx;
            end
            if (w_capture) begin
                o_rsp_w    <= i_alu_w;
                o_rsp_zero <= i_alu_zero;
                o_rsp_neg  <= i_alu_neg;
                r_ptr      <= w_owner_inc;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: behavioural ALU on the alu ports plus a scoreboard ALU fed with the granted
// requester's own operands; expectations queued at grant and compared at the result pulse.
module tb_alu_share_arbiter;
    localparam int NREQ = 4, W = 16, FW = 3;
    logic clk = 1'b0;
    logic rst_n;
    logic [NREQ-1:0]    req, req_cin, gnt, rsp_valid, hold;
    logic [NREQ*W-1:0]  req_a, req_b;
    logic [NREQ*FW-1:0] req_func;
    logic [W-1:0]       rsp_w, alu_a, alu_b, alu_w;
    logic               rsp_zero, rsp_neg, busy, alu_cin, alu_zero, alu_neg;
    logic [FW-1:0]      alu_func;
    logic [W-1:0]       a_op [NREQ];
    logic [W-1:0]       b_op [NREQ];
    logic               cin_op [NREQ];
    logic [FW-1:0]      f_op [NREQ];
    typedef struct {int idx; logic [W-1:0] w; logic z; logic n;} exp_t;
    exp_t sb[$];
    int   glog[$];
    int   chk_cnt = 0, err_cnt = 0;

    always #5 clk = ~clk;

    // returns {zero, neg, w}
    function automatic logic [W+1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic [FW-1:0] f);
        logic [W-1:0] w;
        case (f)
            3'd0: w = a + b + W'(cin);
            3'd1: w = a - b - W'(cin);
            3'd2: w = a & b;
            3'd3: w = a | b;
            3'd4: w = a ^ b;
            3'd5: w = ~a;
            3'd6: w = a << 1;
            default: w = b;
        endcase
        return {w == '0, w[W-1], w};
    endfunction

    assign {alu_zero, alu_neg, alu_w} = alu_f(alu_a, alu_b, alu_cin, alu_func);

    always_comb begin
        req_a = '0; req_b = '0; req_cin = '0; req_func = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W]     = a_op[i];
            req_b[i*W +: W]     = b_op[i];
            req_cin[i]          = cin_op[i];
            req_func[i*FW +: FW] = f_op[i];
        end
    end

    alu_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .FUNCW(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(req), .i_req_a(req_a), .i_req_b(req_b), .i_req_cin(req_cin), .i_req_func(req_func),
        .o_gnt(gnt), .o_rsp_valid(rsp_valid), .o_rsp_w(rsp_w), .o_rsp_zero(rsp_zero),
        .o_rsp_neg(rsp_neg), .o_busy(busy),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_cin(alu_cin), .o_alu_func(alu_func),
        .i_alu_w(alu_w), .i_alu_zero(alu_zero), .i_alu_neg(alu_neg)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // one cycle: sample at negedge, log grants into the scoreboard, check result pulses
    task automatic tick();
        @(negedge clk);
        if (gnt != '0) begin
            int i = 0;
            logic [W+1:0] r;
            chk("gnt_onehot", 32'($onehot(gnt)), 1);
            for (int k = 0; k < NREQ; k++) if (gnt[k]) i = k;
            chk("alu_a_latched", alu_a, a_op[i]);
            chk("alu_b_latched", alu_b, b_op[i]);
            chk("alu_cin_latched", alu_cin, cin_op[i]);
            chk("alu_func_latched", alu_func, f_op[i]);
            r = alu_f(a_op[i], b_op[i], cin_op[i], f_op[i]);
            sb.push_back(exp_t'{i, r[W-1:0], r[W+1], r[W]});
            glog.push_back(i);
            if (!hold[i]) req[i] = 1'b0;
        end
        if (rsp_valid != '0) begin
            if (sb.size() == 0) chk("rsp_spurious", rsp_valid, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_valid", rsp_valid, 32'(1) << e.idx);
                chk("rsp_w", rsp_w, e.w);
                chk("rsp_zero", rsp_zero, e.z);
                chk("rsp_neg", rsp_neg, e.n);
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && (sb.size() != 0 || busy); k++) tick();
        chk("drain_done", (sb.size() == 0) && !busy, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; hold = '0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            a_op[i] = W'($urandom); b_op[i] = W'($urandom);
            cin_op[i] = 1'($urandom); f_op[i] = FW'($urandom_range(0, 7));
        end
    endtask

    initial begin
        rst_n = 1'b0; hold = '0;
        rand_ops();
        req = 4'hF;
        repeat (2) @(negedge clk);
        chk("t1_rst_gnt", gnt, 0);
        chk("t1_rst_rsp_valid", rsp_valid, 0);
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_alu_a", alu_a, 0);
        chk("t1_rst_alu_func", alu_func, 0);
        chk("t1_rst_rsp_w", rsp_w, 0);
        rst_n = 1'b1;
        tick();
        chk("t1_first_gnt", gnt, 4'b0001);
        drain();

        do_reset();
        a_op[0] = 16'h0005; b_op[0] = 16'h0003; cin_op[0] = 1'b0; f_op[0] = 3'd0;
        req = 4'b0001;
        tick();
        chk("t2_gnt", gnt, 4'b0001);
        chk("t2_alu_a", alu_a, 16'h0005);
        chk("t2_alu_b", alu_b, 16'h0003);
        chk("t2_busy", busy, 1);
        tick();
        chk("t2_gnt_pulse", gnt, 0);
        chk("t2_rsp_valid", rsp_valid, 4'b0001);
        chk("t2_rsp_w", rsp_w, 16'h0008);
        drain();

        do_reset();
        rand_ops();
        req = 4'hF;
        for (int k = 0; k < NREQ; k++) begin
            tick();
            chk("t3_gnt_order", gnt, 32'(1) << k);
            chk("t3_busy", busy, 1);
            if (k > 0) chk("t3_rsp_order", rsp_valid, 32'(1) << (k - 1));
        end
        tick();
        chk("t3_last_rsp", rsp_valid, 4'b1000);
        chk("t3_no_gnt", gnt, 0);
        tick();
        chk("t3_busy_drop", busy, 0);
        chk("t3_rsp_idle", rsp_valid, 0);

        glog.delete();
        rand_ops();
        hold = 4'b0101; req = 4'b0101;
        repeat (8) tick();
        chk("t4_grant_count", glog.size(), 8);
        for (int k = 0; k < glog.size(); k++) begin
            chk("t4_member", (glog[k] == 0) || (glog[k] == 2), 1);
            if (k > 0) chk("t4_alternate", glog[k] != glog[k-1], 1);
        end
        hold = '0; req = '0;
        drain();

        do_reset();
        rand_ops();
        hold = 4'b0010; req = 4'b0010;
        tick();
        chk("t5_gnt", gnt, 4'b0010);
        rst_n = 1'b0;
        sb.delete();
        tick();
        chk("t5_rst_rsp", rsp_valid, 0);
        chk("t5_rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        chk("t5_fresh_gnt", gnt, 4'b0010);
        chk("t5_no_stale_rsp", rsp_valid, 0);
        req = '0; hold = '0;
        tick();
        chk("t5_fresh_rsp", rsp_valid, 4'b0010);
        drain();

        a_op[3] = 16'h1234; b_op[3] = 16'h1234; cin_op[3] = 1'b0; f_op[3] = 3'd1;
        req = 4'b1000;
        repeat (2) tick();
        chk("t6_sub_zero", rsp_zero, 1);
        chk("t6_sub_neg", rsp_neg, 0);
        a_op[2] = 16'h4000; b_op[2] = 16'h4000; cin_op[2] = 1'b0; f_op[2] = 3'd0;
        req = 4'b0100;
        repeat (2) tick();
        chk("t6_neg_w", rsp_w, 16'h8000);
        chk("t6_neg_flag", rsp_neg, 1);
        chk("t6_neg_zero", rsp_zero, 0);
        repeat (2) tick();
        chk("t6_hold_w", rsp_w, 16'h8000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
        $finish;
    end
endmodule
